// File: rtl/mlp_sequencer.sv
// Time-multiplexed MLP sequencer (one 32x16 multiplier, 48-bit acc, ReLU-clamped hidden layer). MLP_SEQ_SAT_EN: saturating acc.
// Latency: done 123 cycles after start at defaults. Backpressure: none; start is ignored while busy or in DONE.
module mlp_sequencer #(
  parameter int N_IN  = 6,
  parameter int N_HID = 7,
  parameter int AW    = 6
) (
  input  logic          ADC_CLK_10,
  input  logic          clear,
  input  logic          start,
  output logic [2:0]    in_addr,
  input  logic [31:0]   in_data,
  output logic [AW-1:0] w_addr,
  input  logic [15:0]   w_data,
  output logic          busy,
  output logic          done,
  output logic [31:0]   y,
  output logic [3:0]    resultado
);
  localparam int CW     = $clog2(((N_IN > N_HID) ? N_IN : N_HID) + 1);
  localparam int O_BASE = N_HID * (N_IN + 1);

  typedef enum logic [2:0] {
    IDLE, H_ADDR, H_ACC, H_ACT, O_ADDR, O_ACC, CLASSIFY, DONE
  } state_t;

  state_t state, state_nx;

  logic [CW-1:0]      h_cnt, k_cnt;
  logic signed [47:0] acc;
  logic signed [15:0] hid [N_HID];
  logic signed [31:0] y_hold;

  logic               out_phase, bias_term;
  logic signed [15:0] hid_sel;
  logic signed [31:0] mul_a;
  logic signed [47:0] prod, term, acc_sum;
  logic signed [31:0] h_val, y_cl;
  logic signed [15:0] h_relu;
  logic [3:0]         class_code;

  always_ff @(posedge ADC_CLK_10 or posedge clear) begin
    if (clear) state <= IDLE;
    else       state <= state_nx;
  end

  // Addresses follow the term counters, so they stay stable across each ADDR/ACC pair.
  always_comb begin
    state_nx  = state;
    in_addr   = '0;
    w_addr    = '0;
    out_phase = (state == O_ADDR) || (state == O_ACC);
    case (state)
      IDLE:     if (start) state_nx = H_ADDR;
      H_ADDR:   state_nx = H_ACC;
      H_ACC:    state_nx = (k_cnt == CW'(N_IN)) ? H_ACT : H_ADDR;
      H_ACT:    state_nx = (h_cnt == CW'(N_HID - 1)) ? O_ADDR : H_ADDR;
      O_ADDR:   state_nx = O_ACC;
      O_ACC:    state_nx = (k_cnt == CW'(N_HID)) ? CLASSIFY : O_ADDR;
      CLASSIFY: state_nx = DONE;
      DONE:     state_nx = IDLE;
      default:  state_nx = IDLE;
    endcase
    if (out_phase) begin
      w_addr = AW'(O_BASE + int'(k_cnt));
    end else begin
      w_addr = AW'(int'(h_cnt) * (N_IN + 1) + int'(k_cnt));
      if (k_cnt < CW'(N_IN)) in_addr = 3'(k_cnt);
    end
  end

  always_comb begin
    hid_sel   = (k_cnt < CW'(N_HID)) ? hid[k_cnt] : '0;
    mul_a     = out_phase ? 32'(hid_sel) : $signed(in_data);
    prod      = 48'(mul_a) * 48'($signed(w_data));
    bias_term = out_phase ? (k_cnt == CW'(N_HID)) : (k_cnt == CW'(N_IN));
    term      = prod;
    if (bias_term)
      term = out_phase ? {{24{w_data[15]}}, w_data, 8'h00}
                       : {{16{w_data[15]}}, w_data, 16'h0000};
  end

`ifdef MLP_SEQ_SAT_EN
  logic signed [48:0] sum_wide;

  always_comb begin
    sum_wide = {acc[47], acc} + {term[47], term};
    acc_sum  = sum_wide[47:0];
    if (sum_wide[48] != sum_wide[47])
      acc_sum = sum_wide[48] ? {1'b1, 47'b0} : {1'b0, {47{1'b1}}};
    y_cl = acc[31:0];
    if (acc[47:31] != {17{acc[47]}})
      y_cl = acc[47] ? 32'sh8000_0000 : 32'sh7FFF_FFFF;
  end
`else
  always_comb begin
    acc_sum = acc + term;
    y_cl    = acc[31:0];
  end
`endif

  always_comb begin
    h_val  = acc[47:16];
    h_relu = h_val[15:0];
    if (h_val > 32'sd256)  h_relu = 16'sd256;
    else if (h_val < 0)    h_relu = '0;
    if (y_hold > 32'sh9999)      class_code = 4'd4;
    else if (y_hold > 32'sh8000) class_code = 4'd5;
    else if (y_hold > 32'sh6666) class_code = 4'd6;
    else                         class_code = 4'd2;
  end

  always_ff @(posedge ADC_CLK_10 or posedge clear) begin
    if (clear) begin
      busy      <= 1'b0;
      done      <= 1'b0;
      y         <= '0;
      resultado <= '0;
      acc       <= '0;
      y_hold    <= '0;
      h_cnt     <= '0;
      k_cnt     <= '0;
      for (int i = 0; i < N_HID; i++) hid[i] <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: if (start) begin
          busy  <= 1'b1;
          acc   <= '0;
          h_cnt <= '0;
          k_cnt <= '0;
        end
        H_ACC, O_ACC: begin
          acc   <= acc_sum;
          k_cnt <= bias_term ? '0 : k_cnt + CW'(1);
        end
        H_ACT: begin
          hid[h_cnt] <= h_relu;
          acc        <= '0;
          h_cnt      <= (h_cnt == CW'(N_HID - 1)) ? '0 : h_cnt + CW'(1);
        end
        CLASSIFY: begin
          y_hold <= y_cl;
          acc    <= '0;
        end
        DONE: begin
          y         <= y_hold;
          resultado <= class_code;
          done      <= 1'b1;
          busy      <= 1'b0;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_mlp_sequencer.sv
// Bench for mlp_sequencer: fixed-pattern vector table, multi-cycle control sequences, randomized runs vs arithmetic model.
module tb_mlp_sequencer;
  localparam int N_IN = 6, N_HID = 7, AW = 6, O_BASE = 49;

  logic          ADC_CLK_10 = 1'b0;
  logic          clear, start;
  logic [2:0]    in_addr;
  logic [31:0]   in_data;
  logic [AW-1:0] w_addr;
  logic [15:0]   w_data;
  logic          busy, done;
  logic [31:0]   y;
  logic [3:0]    resultado;

  logic [31:0] imem [0:7];
  logic [15:0] wmem [0:63];
  int n_run = 0, n_fail = 0;

  mlp_sequencer #(.N_IN(N_IN), .N_HID(N_HID), .AW(AW)) dut (
    .ADC_CLK_10(ADC_CLK_10), .clear(clear), .start(start),
    .in_addr(in_addr), .in_data(in_data), .w_addr(w_addr), .w_data(w_data),
    .busy(busy), .done(done), .y(y), .resultado(resultado)
  );

  always #5 ADC_CLK_10 = ~ADC_CLK_10;

  always @(posedge ADC_CLK_10) begin
    in_data <= imem[in_addr];
    w_data  <= wmem[w_addr];
  end

  typedef struct {
    logic [31:0] iv;
    logic [15:0] hw, hb, ow, ob;
    logic [31:0] ey;
    logic [3:0]  er;
  } vec_t;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_run++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  task automatic load(input logic [31:0] iv, input logic [15:0] hw, hb, ow, ob);
    for (int k = 0; k < 8; k++) imem[k] = (k < N_IN) ? iv : 32'h0;
    for (int a = 0; a < 64; a++) wmem[a] = 16'h0;
    for (int h = 0; h < N_HID; h++) begin
      for (int k = 0; k < N_IN; k++) wmem[h*(N_IN+1)+k] = hw;
      wmem[h*(N_IN+1)+N_IN] = hb;
      wmem[O_BASE+h] = ow;
    end
    wmem[O_BASE+N_HID] = ob;
  endtask

  function automatic longint fix48(input longint v);
`ifdef MLP_SEQ_SAT_EN
    if (v > 64'sh7FFF_FFFF_FFFF) return 64'sh7FFF_FFFF_FFFF;
    if (v < -64'sh8000_0000_0000) return -64'sh8000_0000_0000;
    return v;
`else
    longint t;
    t = v <<< 16;
    return t >>> 16;
`endif
  endfunction

  task automatic model(output logic [31:0] ey, output logic [3:0] er);
    longint acc, a, b;
    longint hv [N_HID];
    int yi;
    for (int h = 0; h < N_HID; h++) begin
      acc = 0;
      for (int k = 0; k < N_IN; k++) begin
        a = $signed(imem[k]);
        b = $signed(wmem[h*(N_IN+1)+k]);
        acc = fix48(acc + a * b);
      end
      b = $signed(wmem[h*(N_IN+1)+N_IN]);
      acc = fix48(acc + b * 65536);
      hv[h] = acc >>> 16;
      if (hv[h] > 256) hv[h] = 256;
      else if (hv[h] < 0) hv[h] = 0;
    end
    acc = 0;
    for (int h = 0; h < N_HID; h++) begin
      b = $signed(wmem[O_BASE+h]);
      acc = fix48(acc + hv[h] * b);
    end
    b = $signed(wmem[O_BASE+N_HID]);
    acc = fix48(acc + b * 256);
`ifdef MLP_SEQ_SAT_EN
    if (acc > 64'sd2147483647) acc = 64'sd2147483647;
    else if (acc < -64'sd2147483648) acc = -64'sd2147483648;
`endif
    ey = acc[31:0];
    yi = $signed(ey);
    if (yi > 39321)      er = 4'd4;
    else if (yi > 32768) er = 4'd5;
    else if (yi > 26214) er = 4'd6;
    else                 er = 4'd2;
  endtask

  task automatic wait_done(output int lat);
    lat = 0;
    do begin
      @(posedge ADC_CLK_10); #1;
      lat++;
    end while (!done && lat < 400);
  endtask

  task automatic run_once(input string tag, output logic [31:0] yo, output logic [3:0] ro);
    int lat;
    start = 1'b1;
    @(posedge ADC_CLK_10); #1;
    start = 1'b0;
    check({tag, ".busy_rise"}, 64'(busy), 64'd1);
    wait_done(lat);
    check({tag, ".latency"}, 64'(lat), 64'd123);
    check({tag, ".busy_fall"}, 64'(busy), 64'd0);
    yo = y;
    ro = resultado;
  endtask

  initial begin
    vec_t vt [11];
    logic [31:0] yo, ey;
    logic [3:0]  ro, er;
    int lat, n_done;

    vt[0]  = '{32'h0,     16'h0000, 16'h0000, 16'h0000, 16'h0000, 32'h0000_0000, 4'd2};
    vt[1]  = '{32'h10000, 16'h0011, 16'h0011, 16'h0011, 16'h0011, 32'h0000_4851, 4'd2};
    vt[2]  = '{32'h10000, 16'h0100, 16'h0100, 16'h0010, 16'h0018, 32'h0000_8800, 4'd5};
    vt[3]  = '{32'h10000, 16'hFF00, 16'hFF00, 16'h0000, 16'h0070, 32'h0000_7000, 4'd6};
    vt[4]  = '{32'h10000, 16'h0100, 16'h0100, 16'h0100, 16'h0100, 32'h0008_0000, 4'd4};
    vt[5]  = '{32'h10000, 16'h0100, 16'h0100, 16'hFF00, 16'h0000, 32'hFFF9_0000, 4'd2};
    vt[6]  = '{32'h10000, 16'h0100, 16'h0100, 16'h0010, 16'h0010, 32'h0000_8000, 4'd6};
    vt[7]  = '{32'h10000, 16'h0100, 16'h0100, 16'h0010, 16'h0029, 32'h0000_9900, 4'd5};
    vt[8]  = '{32'h10000, 16'h0100, 16'h0100, 16'h0010, 16'h002A, 32'h0000_9A00, 4'd4};
    vt[9]  = '{32'h10000, 16'h0000, 16'h0101, 16'h0010, 16'h0000, 32'h0000_7000, 4'd6};
    vt[10] = '{32'h0,     16'h0000, 16'hFFFF, 16'h0100, 16'h0001, 32'h0000_0100, 4'd2};

    clear = 1'b1;
    start = 1'b0;
    load(32'h0, 16'h0, 16'h0, 16'h0, 16'h0);
    #2;
    check("reset.busy", 64'(busy), 64'd0);
    check("reset.done", 64'(done), 64'd0);
    check("reset.y", 64'(y), 64'd0);
    check("reset.resultado", 64'(resultado), 64'd0);
    check("reset.in_addr", 64'(in_addr), 64'd0);
    check("reset.w_addr", 64'(w_addr), 64'd0);
    repeat (2) @(posedge ADC_CLK_10);
    @(negedge ADC_CLK_10) clear = 1'b0;
    @(posedge ADC_CLK_10); #1;

    for (int i = 0; i < 11; i++) begin
      load(vt[i].iv, vt[i].hw, vt[i].hb, vt[i].ow, vt[i].ob);
      run_once($sformatf("vec%0d", i), yo, ro);
      check($sformatf("vec%0d.y", i), 64'(yo), 64'(vt[i].ey));
      check($sformatf("vec%0d.resultado", i), 64'(ro), 64'(vt[i].er));
    end

    // Asynchronous clear in the middle of a run.
    load(vt[2].iv, vt[2].hw, vt[2].hb, vt[2].ow, vt[2].ob);
    start = 1'b1;
    @(posedge ADC_CLK_10); #1;
    start = 1'b0;
    repeat (50) @(posedge ADC_CLK_10);
    #3 clear = 1'b1;
    #1;
    check("abort.busy", 64'(busy), 64'd0);
    check("abort.resultado", 64'(resultado), 64'd0);
    check("abort.y", 64'(y), 64'd0);
    check("abort.w_addr", 64'(w_addr), 64'd0);
    @(negedge ADC_CLK_10) clear = 1'b0;
    n_done = 0;
    repeat (200) begin
      @(posedge ADC_CLK_10); #1;
      if (done) n_done++;
    end
    check("abort.no_done", 64'(n_done), 64'd0);
    check("abort.idle_busy", 64'(busy), 64'd0);
    run_once("post_abort", yo, ro);
    check("post_abort.y", 64'(yo), 64'h8800);
    check("post_abort.resultado", 64'(ro), 64'd5);

    // A start pulse while busy must not shift or queue a run.
    load(vt[4].iv, vt[4].hw, vt[4].hb, vt[4].ow, vt[4].ob);
    start = 1'b1;
    @(posedge ADC_CLK_10); #1;
    start = 1'b0;
    lat = 0;
    repeat (60) begin @(posedge ADC_CLK_10); #1; lat++; end
    start = 1'b1;
    @(posedge ADC_CLK_10); #1;
    lat++;
    start = 1'b0;
    while (!done && lat < 400) begin @(posedge ADC_CLK_10); #1; lat++; end
    check("busy_start.latency", 64'(lat), 64'd123);
    check("busy_start.y", 64'(y), 64'h80000);
    n_done = 0;
    repeat (200) begin
      @(posedge ADC_CLK_10); #1;
      if (done) n_done++;
    end
    check("busy_start.not_queued", 64'(n_done), 64'd0);

    // start held high: next run is accepted from IDLE right after the done cycle.
    load(vt[7].iv, vt[7].hw, vt[7].hb, vt[7].ow, vt[7].ob);
    start = 1'b1;
    @(posedge ADC_CLK_10); #1;
    wait_done(lat);
    check("held.first_latency", 64'(lat), 64'd123);
    check("held.first_y", 64'(y), 64'h9900);
    wait_done(lat);
    check("held.second_latency", 64'(lat), 64'd124);
    check("held.second_resultado", 64'(resultado), 64'd5);
    start = 1'b0;
    repeat (3) begin @(posedge ADC_CLK_10); #1; end
    check("held.idle_busy", 64'(busy), 64'd0);

    for (int r = 0; r < 12; r++) begin
      if (r == 0) begin
        load(32'h7FFF_FFFF, 16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF);
      end else begin
        load(32'h0, 16'h0, 16'h0, 16'h0, 16'h0);
        for (int k = 0; k < N_IN; k++)
          imem[k] = (r < 5) ? $urandom : 32'($urandom_range(0, 32'h80000)) - 32'h40000;
        for (int a = 0; a <= O_BASE + N_HID; a++)
          wmem[a] = (r < 5) ? 16'($urandom) : 16'($urandom_range(0, 32'h200) - 32'h100);
      end
      model(ey, er);
      run_once($sformatf("rand%0d", r), yo, ro);
      check($sformatf("rand%0d.y", r), 64'(yo), 64'(ey));
      check($sformatf("rand%0d.resultado", r), 64'(ro), 64'(er));
    end

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end
endmodule
